// File: rtl/sfp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sfp_pkg
//  Brief    : Shared constants, state encoding and helpers for the SFP
//             telemetry framer (header layout, frame sizing).
//  Revision : 1.0 - initial release
// ============================================================================
package sfp_pkg;

    // Start-of-frame marker in the top byte of every header word
    localparam logic [7:0] c_SOF = 8'hA5;

    // Header field offsets (LSB positions inside the 64-bit header word)
    localparam int c_HDR_SOF_LSB  = 56;
    localparam int c_HDR_NODE_LSB = 48;
    localparam int c_HDR_SEQ_LSB  = 32;
    localparam int c_HDR_NW_LSB   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_e;

    // Number of 64-bit data words needed to carry n_ch 32-bit channels
    function automatic int nw(input int n_ch);
        return (n_ch + 1) / 2;
    endfunction

    // Assemble the header word; the low 16 bits are reserved as zero
    function automatic logic [63:0] build_header(input logic [7:0]  node,
                                                 input logic [15:0] seq,
                                                 input logic [15:0] nwords);
        logic [63:0] h;
        h = '0;
        h[c_HDR_SOF_LSB  +: 8]  = c_SOF;
        h[c_HDR_NODE_LSB +: 8]  = node;
        h[c_HDR_SEQ_LSB  +: 16] = seq;
        h[c_HDR_NW_LSB   +: 16] = nwords;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfp_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sfp_frame_timer
//  Brief    : Free-running period counter producing a one-cycle tick on its
//             terminal count; parked at zero while disabled or period is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sfp_frame_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_tick
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic                w_run;
    logic                w_term;

    // Terminal count uses >= so a period shrunk below the count wraps at once
    always_comb begin
        w_run  = i_en && (i_period != '0);
        w_term = w_run && (cnt_q >= (i_period - PERIOD_W'(1)));
        cnt_d  = '0;
        if (w_run && !w_term) begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = w_term;

endmodule
`default_nettype wire

// File: rtl/sfp_telemetry_framer.sv
`default_nettype none
// ============================================================================
//  Module   : sfp_telemetry_framer
//  Brief    : Snapshots N_CH telemetry channels on a tick or manual trigger
//             and streams header, packed channel pairs and XOR checksum on a
//             64-bit AXI4-Stream master.
//  Revision : 1.0 - initial release
// ============================================================================
module sfp_telemetry_framer
    import sfp_pkg::*;
#(
    parameter int N_CH     = 9,
    parameter int PERIOD_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [7:0]           i_node_id,
    input  logic [PERIOD_W-1:0]  i_period,
    input  logic                 i_trig,
    input  logic [N_CH*32-1:0]   i_ch_data,
    output logic [63:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 o_busy,
    output logic [15:0]          o_seq,
    output logic                 o_overrun
);

    localparam int c_NW    = nw(N_CH);
    localparam int c_IDX_W = (c_NW > 1) ? $clog2(c_NW) : 1;

    state_e               state_q, state_d;
    logic [N_CH*32-1:0]   snap_q, snap_d;
    logic [7:0]           node_q, node_d;
    logic [63:0]          acc_q, acc_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]          seq_q, seq_d;
    logic                 ovr_q, ovr_d;
    logic                 en_q;

    logic                 w_tick;
    logic                 w_trig;
    logic                 w_hs;
    logic                 w_en_fall;
    logic [c_NW*64-1:0]   w_padded;
    logic [63:0]          w_words [c_NW];

    sfp_frame_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_period (i_period),
        .o_tick   (w_tick)
    );

    assign w_trig        = w_tick | (i_trig & i_en);
    assign w_hs          = m_axis_tvalid & m_axis_tready;
    assign w_en_fall     = en_q & ~i_en;
    assign m_axis_tvalid = (state_q != IDLE);
    assign m_axis_tlast  = (state_q == CSUM);
    assign o_busy        = (state_q != IDLE);
    assign o_seq         = seq_q;
    assign o_overrun     = ovr_q;

    // Split the snapshot into 64-bit channel pairs; an odd tail pads with zero
    always_comb begin
        w_padded                 = '0;
        w_padded[N_CH*32-1:0]    = snap_q;
        for (int j = 0; j < c_NW; j++) begin
            w_words[j] = w_padded[j*64 +: 64];
        end
    end

    // Word mux: everything comes from registers, so data holds while stalled
    always_comb begin
        case (state_q)
            HDR:     m_axis_tdata = build_header(node_q, seq_q, 16'(c_NW));
            DATA:    m_axis_tdata = w_words[idx_q];
            CSUM:    m_axis_tdata = acc_q;
            default: m_axis_tdata = '0;
        endcase
    end

    // Next-state, snapshot capture, checksum accumulation and overrun tracking
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        node_d  = node_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        ovr_d   = ovr_q;

        if (w_en_fall) begin
            ovr_d = 1'b0;
        end
        if (w_hs) begin
            acc_d = acc_q ^ m_axis_tdata;
        end

        case (state_q)
            IDLE: begin
                if (w_trig) begin
                    state_d = HDR;
                    snap_d  = i_ch_data;
                    node_d  = i_node_id;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            HDR: begin
                if (w_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    if (idx_q == c_IDX_W'(c_NW - 1)) begin
                        state_d = CSUM;
                    end else begin
                        idx_d = idx_q + c_IDX_W'(1);
                    end
                end
            end
            CSUM: begin
                if (w_hs) begin
                    state_d = IDLE;
                    seq_d   = seq_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Triggers are never queued; any trigger outside IDLE is lost
        if (w_trig && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            snap_q <= '0;
            node_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            seq_q  <= '0;
            ovr_q  <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            snap_q <= snap_d;
            node_q <= node_d;
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            seq_q  <= seq_d;
            ovr_q  <= ovr_d;
            en_q   <= i_en;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sfp_telemetry_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sfp_telemetry_framer
//  Brief    : Directed self-checking bench for sfp_telemetry_framer using a
//             nine-channel and a single-channel instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sfp_telemetry_framer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          trig;
    logic          tready;
    logic [7:0]    node;
    logic [15:0]   period;
    logic [287:0]  ch9;
    logic [31:0]   ch1;

    logic [63:0]   tdata9, tdata1;
    logic          tvalid9, tvalid1, tlast9, tlast1;
    logic          busy9, busy1, ovr9, ovr1;
    logic [15:0]   seq9, seq1;

    int            checks = 0;
    int            errors = 0;

    logic          sel1 = 1'b0;
    logic [63:0]   obs_tdata;
    logic          obs_tvalid;
    logic          obs_tlast;

    logic [63:0]   cap_w [0:7];
    logic          cap_l [0:7];
    int            cap_n;
    int            cap_cycles;
    int            cap_stall_err;
    bit            cap_timeout;

    always #5 clk = ~clk;

    sfp_telemetry_framer #(.N_CH(9), .PERIOD_W(16)) dut9 (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_node_id(node),
        .i_period(period), .i_trig(trig), .i_ch_data(ch9),
        .m_axis_tdata(tdata9), .m_axis_tvalid(tvalid9),
        .m_axis_tready(tready), .m_axis_tlast(tlast9),
        .o_busy(busy9), .o_seq(seq9), .o_overrun(ovr9)
    );

    sfp_telemetry_framer #(.N_CH(1), .PERIOD_W(16)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_node_id(node),
        .i_period(period), .i_trig(trig), .i_ch_data(ch1),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
        .m_axis_tready(tready), .m_axis_tlast(tlast1),
        .o_busy(busy1), .o_seq(seq1), .o_overrun(ovr1)
    );

    always_comb begin
        obs_tdata  = sel1 ? tdata1  : tdata9;
        obs_tvalid = sel1 ? tvalid1 : tvalid9;
        obs_tlast  = sel1 ? tlast1  : tlast9;
    end

    // Records accepted words starting at a negedge in the first frame cycle
    task automatic capture(input bit toggle);
        int          first;
        bit          prev_stall;
        logic [63:0] prev_d;
        bit          done;
        cap_n = 0; cap_cycles = 0; cap_stall_err = 0; cap_timeout = 1'b0;
        first = -1; prev_stall = 1'b0; prev_d = '0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tready = toggle ? (k % 2 == 0) : 1'b1;
            #1;
            if (obs_tvalid && first < 0) first = k;
            if (prev_stall && obs_tdata !== prev_d) cap_stall_err++;
            prev_stall = obs_tvalid && !tready;
            prev_d     = obs_tdata;
            if (obs_tvalid && tready) begin
                if (cap_n < 8) begin
                    cap_w[cap_n] = obs_tdata;
                    cap_l[cap_n] = obs_tlast;
                end
                cap_n++;
                if (obs_tlast) begin
                    done       = 1'b1;
                    cap_cycles = k - first + 1;
                end
            end
            @(negedge clk);
        end
        tready = 1'b1;
        if (!done) cap_timeout = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (tvalid9 !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %0b want 0", tvalid9); end
        checks++; if (tdata9 !== 64'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", tdata9); end
        checks++; if (tlast9 !== 1'b0) begin errors++; $display("FAIL rst_tlast got %0b want 0", tlast9); end
        checks++; if (busy9 !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy9); end
        checks++; if (seq9 !== 16'h0) begin errors++; $display("FAIL rst_seq got %h want 0", seq9); end
        checks++; if (ovr9 !== 1'b0) begin errors++; $display("FAIL rst_overrun got %0b want 0", ovr9); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (tvalid9 !== 1'b0 || tdata9 !== 64'h0) begin
            errors++; $display("FAIL idle_outputs tvalid=%0b tdata=%h want 0/0", tvalid9, tdata9);
        end
    endtask

    task automatic test_basic();
        logic [63:0] exp [0:6];
        exp = '{64'hA503_0000_0005_0000, 64'h1000_0001_1000_0000,
                64'h1000_0003_1000_0002, 64'h1000_0005_1000_0004,
                64'h1000_0007_1000_0006, 64'h0000_0000_1000_0008,
                64'hA503_0000_1005_0008};
        pulse_trig();
        #1;
        checks++; if (tvalid9 !== 1'b1) begin errors++; $display("FAIL basic_latency tvalid got %0b want 1", tvalid9); end
        checks++; if (busy9 !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", busy9); end
        capture(1'b0);
        checks++; if (cap_timeout || cap_n != 7) begin errors++; $display("FAIL basic_count got %0d want 7", cap_n); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap_w[i] !== exp[i]) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, cap_w[i], exp[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap_l[i] !== 1'b0) begin errors++; $display("FAIL basic_tlast_early word%0d got %0b want 0", i, cap_l[i]); end
        end
        checks++; if (cap_l[6] !== 1'b1) begin errors++; $display("FAIL basic_tlast got %0b want 1", cap_l[6]); end
        checks++; if (cap_cycles != 7) begin errors++; $display("FAIL basic_cycles got %0d want 7", cap_cycles); end
        #1;
        checks++; if (seq9 !== 16'd1) begin errors++; $display("FAIL basic_seq got %0d want 1", seq9); end
        checks++; if (busy9 !== 1'b0 || tvalid9 !== 1'b0) begin
            errors++; $display("FAIL basic_idle busy=%0b tvalid=%0b want 0/0", busy9, tvalid9);
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp [0:6];
        exp = '{64'hA503_0001_0005_0000, 64'h1000_0001_1000_0000,
                64'h1000_0003_1000_0002, 64'h1000_0005_1000_0004,
                64'h1000_0007_1000_0006, 64'h0000_0000_1000_0008,
                64'hA503_0001_1005_0008};
        pulse_trig();
        node = 8'h7E;
        capture(1'b1);
        node = 8'h03;
        checks++; if (cap_timeout || cap_n != 7) begin errors++; $display("FAIL stall_count got %0d want 7", cap_n); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap_w[i] !== exp[i]) begin errors++; $display("FAIL stall_word%0d got %h want %h", i, cap_w[i], exp[i]); end
        end
        checks++; if (cap_stall_err != 0) begin errors++; $display("FAIL stall_hold changes got %0d want 0", cap_stall_err); end
        checks++; if (cap_cycles != 13) begin errors++; $display("FAIL stall_cycles got %0d want 13", cap_cycles); end
        #1;
        checks++; if (seq9 !== 16'd2) begin errors++; $display("FAIL stall_seq got %0d want 2", seq9); end
    endtask

    task automatic test_overrun();
        int hi;
        pulse_trig();
        #1;
        checks++; if (ovr9 !== 1'b0) begin errors++; $display("FAIL ovr_pre got %0b want 0", ovr9); end
        @(negedge clk);
        @(negedge clk);
        trig = 1'b1;
        #1;
        checks++; if (tdata9 !== 64'h1000_0003_1000_0002) begin
            errors++; $display("FAIL ovr_word3 got %h want %h", tdata9, 64'h1000_0003_1000_0002);
        end
        @(negedge clk);
        trig = 1'b0;
        #1;
        for (int i = 0; i < 20 && tvalid9; i++) begin
            @(negedge clk);
            #1;
        end
        checks++; if (tvalid9 !== 1'b0) begin errors++; $display("FAIL ovr_frame_end tvalid got %0b want 0", tvalid9); end
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (tvalid9) hi++;
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL ovr_no_second_frame valid_cycles got %0d want 0", hi); end
        checks++; if (seq9 !== 16'd3) begin errors++; $display("FAIL ovr_seq got %0d want 3", seq9); end
        checks++; if (ovr9 !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b want 1", ovr9); end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (ovr9 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b want 0", ovr9); end
        en = 1'b1;
    endtask

    task automatic test_periodic();
        int          hdr_n;
        bit          prev_v;
        int          when [0:4];
        logic [15:0] sq [0:4];
        do_reset();
        @(negedge clk);
        en = 1'b1;
        period = 16'd20;
        hdr_n = 0;
        prev_v = 1'b0;
        for (int c = 1; c <= 130 && hdr_n < 5; c++) begin
            @(negedge clk);
            #1;
            if (tvalid9 && !prev_v) begin
                when[hdr_n] = c;
                sq[hdr_n]   = tdata9[47:32];
                hdr_n++;
            end
            prev_v = tvalid9;
        end
        period = 16'd0;
        checks++; if (hdr_n != 5) begin errors++; $display("FAIL per_frames got %0d want 5", hdr_n); end
        if (hdr_n == 5) begin
            checks++; if (when[0] != 20) begin errors++; $display("FAIL per_first got %0d want 20", when[0]); end
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (when[i] - when[i-1] != 20) begin
                    errors++; $display("FAIL per_spacing%0d got %0d want 20", i, when[i] - when[i-1]);
                end
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (sq[i] !== 16'(i)) begin errors++; $display("FAIL per_seq%0d got %0d want %0d", i, sq[i], i); end
            end
        end
        repeat (12) @(negedge clk);
        #1;
        checks++; if (seq9 !== 16'd5) begin errors++; $display("FAIL per_final_seq got %0d want 5", seq9); end
    endtask

    task automatic test_reset_midframe();
        pulse_trig();
        @(negedge clk);
        @(negedge clk);
        tready = 1'b0;
        #1;
        checks++; if (tvalid9 !== 1'b1 || tdata9 !== 64'h1000_0003_1000_0002) begin
            errors++; $display("FAIL rmf_pre tvalid=%0b tdata=%h want 1/%h", tvalid9, tdata9, 64'h1000_0003_1000_0002);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tvalid9 !== 1'b0) begin errors++; $display("FAIL rmf_async_tvalid got %0b want 0", tvalid9); end
        checks++; if (busy9 !== 1'b0) begin errors++; $display("FAIL rmf_async_busy got %0b want 0", busy9); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tready = 1'b1;
        pulse_trig();
        #1;
        checks++; if (tvalid9 !== 1'b1 || tdata9 !== 64'hA503_0000_0005_0000) begin
            errors++; $display("FAIL rmf_new_header tvalid=%0b tdata=%h want 1/%h", tvalid9, tdata9, 64'hA503_0000_0005_0000);
        end
        for (int i = 0; i < 20 && tvalid9; i++) begin
            @(negedge clk);
            #1;
        end
        checks++; if (seq9 !== 16'd1) begin errors++; $display("FAIL rmf_seq got %0d want 1", seq9); end
    endtask

    task automatic test_nch1();
        logic [63:0] exp [0:2];
        exp = '{64'hA503_0000_0001_0000, 64'h0000_0000_DEAD_BEEF, 64'hA503_0000_DEAC_BEEF};
        do_reset();
        sel1 = 1'b1;
        pulse_trig();
        capture(1'b0);
        checks++; if (cap_timeout || cap_n != 3) begin errors++; $display("FAIL n1_count got %0d want 3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap_w[i] !== exp[i]) begin errors++; $display("FAIL n1_word%0d got %h want %h", i, cap_w[i], exp[i]); end
        end
        checks++; if (cap_l[2] !== 1'b1 || cap_l[1] !== 1'b0) begin
            errors++; $display("FAIL n1_tlast got %0b%0b want 01", cap_l[1], cap_l[2]);
        end
        checks++; if (cap_cycles != 3) begin errors++; $display("FAIL n1_cycles got %0d want 3", cap_cycles); end
        #1;
        checks++; if (seq1 !== 16'd1) begin errors++; $display("FAIL n1_seq got %0d want 1", seq1); end
        sel1 = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        trig   = 1'b0;
        tready = 1'b1;
        node   = 8'h03;
        period = 16'd0;
        ch1    = 32'hDEAD_BEEF;
        for (int k = 0; k < 9; k++) begin
            ch9[k*32 +: 32] = 32'(32'h1000_0000 + k);
        end
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_periodic();
        test_reset_midframe();
        test_nch1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
